// File: rtl/dot_product_sequencer_if.sv
// Handshake and MAC operand bundle between the dot-product sequencer
// and its environment (element source, MAC stage, result consumer).
interface dot_product_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic             in_last;
    logic [3:0]       mac_a;
    logic [3:0]       mac_b;
    logic [3:0]       mac_c;
    logic [3:0]       mac_d;
    logic [3:0]       mac_m;
    logic [3:0]       mac_n;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_last,
        output in_ready,
        output mac_a, mac_b, mac_c, mac_d,
        input  mac_m, mac_n,
        output out_valid, out_sum, out_count, out_ovf,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_last,
        input  in_ready,
        input  mac_a, mac_b, mac_c, mac_d,
        output mac_m, mac_n,
        input  out_valid, out_sum, out_count, out_ovf,
        output out_ready
    );
endinterface

// File: rtl/dot_product_sequencer.sv
// Sequential front end for a combinational 4x4+8 MAC: accumulates a dot product.
// Optional DOT_SEQ_SATURATE_EN: clamp the accumulator to 0xFF on wrap.
module dot_product_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    dot_product_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       sum_q, sum_d;
    logic [CNT_W-1:0] ocount_q, ocount_d;
    logic             oovf_q, oovf_d;

    logic [7:0]       feed;
    logic [7:0]       result;
    logic [CNT_W-1:0] count_base;
    logic [CNT_W-1:0] count_inc;
    logic             wrap;
    logic             beat;

    // MAC operand paths are purely combinational; vectors start from a zero feed.
    assign feed       = (state_q == ACCUM) ? acc_q : 8'h00;
    assign result     = {bus.mac_m, bus.mac_n};
    assign wrap       = result < feed;
    assign count_base = (state_q == IDLE) ? '0 : count_q;
    assign count_inc  = (count_base == CNT_MAX) ? CNT_MAX : count_base + 1'b1;

    assign bus.mac_a     = bus.in_a;
    assign bus.mac_b     = bus.in_b;
    assign bus.mac_c     = feed[7:4];
    assign bus.mac_d     = feed[3:0];
    assign bus.in_ready  = (state_q != DONE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_count = ocount_q;
    assign bus.out_ovf   = oovf_q;

    assign beat = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        sum_d    = sum_q;
        ocount_d = ocount_q;
        oovf_d   = oovf_q;

        if (beat) begin
`ifdef DOT_SEQ_SATURATE_EN
            acc_d = wrap ? 8'hFF : result;
`else
            acc_d = result;
`endif
            count_d = count_inc;
            ovf_d   = ((state_q == IDLE) ? 1'b0 : ovf_q) | wrap;
        end

        unique case (state_q)
            IDLE, ACCUM: begin
                if (beat) begin
                    if (bus.in_last) begin
                        state_d  = DONE;
                        sum_d    = acc_d;
                        ocount_d = count_d;
                        oovf_d   = ovf_d;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q  <= IDLE;
            acc_q    <= 8'h00;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            sum_q    <= 8'h00;
            ocount_q <= '0;
            oovf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            sum_q    <= sum_d;
            ocount_q <= ocount_d;
            oovf_q   <= oovf_d;
        end
    end
endmodule
